// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb
//  Brief    : Parametrised register file with a hardwired-zero register 0,
//             an optional write-to-read bypass, and a per-register busy
//             scoreboard used by issue logic to stall on pending writes.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
    parameter  int WIDTH      = 32,
    parameter  int DEPTH      = 8,
    parameter  int BYPASS     = 1,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rnum1,
    input  logic [ADDR_WIDTH-1:0] rnum2,
    output logic [WIDTH-1:0]      rdata1,
    output logic [WIDTH-1:0]      rdata2,
    output logic                  rbusy1,
    output logic                  rbusy2,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] wnum,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  bset,
    input  logic [ADDR_WIDTH-1:0] bnum,
    output logic [DEPTH-1:0]      busy_vec,
    input  logic [ADDR_WIDTH-1:0] dbg_num,
    output logic [WIDTH-1:0]      dbg_data
);

    localparam logic [ADDR_WIDTH-1:0] c_ZERO_ADDR = '0;
    localparam bit                    c_BYPASS_EN = (BYPASS != 0);

    // Qualified write / busy-set strobes. Targets of register 0 are dropped
    // here, and the reset term keeps a write presented while reset is held
    // from leaking onto the read ports through the bypass path.
    logic w_wr_en;
    logic w_bset_en;

    assign w_wr_en   = write & rst & (wnum != c_ZERO_ADDR);
    assign w_bset_en = bset  & rst & (bnum != c_ZERO_ADDR);

    // Committed register contents and busy bits, indexed by register number.
    // Entry 0 is a constant, so no flop exists for it.
    logic [WIDTH-1:0] w_reg_q [DEPTH];
    logic [DEPTH-1:0] w_busy;

    assign w_reg_q[0] = '0;
    assign w_busy[0]  = 1'b0;

    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_entry
        localparam logic [ADDR_WIDTH-1:0] c_IDX = ADDR_WIDTH'(gi);

        logic [WIDTH-1:0] r_data;
        logic             r_busy;

        // Data storage: commit the write data when this register is targeted.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_data <= '0;
            end else if (w_wr_en && (wnum == c_IDX)) begin
                r_data <= wdata;
            end
        end

        // Scoreboard bit: a new producer issuing (bset) takes priority over
        // an older producer completing (write) in the same cycle.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_busy <= 1'b0;
            end else if (w_bset_en && (bnum == c_IDX)) begin
                r_busy <= 1'b1;
            end else if (w_wr_en && (wnum == c_IDX)) begin
                r_busy <= 1'b0;
            end
        end

        assign w_reg_q[gi] = r_data;
        assign w_busy[gi]  = r_busy;
    end

    // Both read ports share identical logic; port 0 maps to rnum1, port 1 to
    // rnum2.
    for (genvar gp = 0; gp < 2; gp++) begin : g_rport
        logic [ADDR_WIDTH-1:0] w_num;
        logic [WIDTH-1:0]      w_data;
        logic                  w_busy_rd;

        assign w_num = (gp == 0) ? rnum1 : rnum2;

        // Read mux with optional forwarding of a same-cycle write. A matching
        // write clears the busy indication unless a bset to the same register
        // in this cycle keeps it busy after the edge.
        always_comb begin
            w_data    = w_reg_q[w_num];
            w_busy_rd = w_busy[w_num];
            if (c_BYPASS_EN && w_wr_en && (wnum == w_num)) begin
                w_data = wdata;
                if (!(w_bset_en && (bnum == w_num))) begin
                    w_busy_rd = 1'b0;
                end
            end
        end
    end

    assign rdata1   = g_rport[0].w_data;
    assign rbusy1   = g_rport[0].w_busy_rd;
    assign rdata2   = g_rport[1].w_data;
    assign rbusy2   = g_rport[1].w_busy_rd;

    assign busy_vec = w_busy;

    // Debug port always shows committed state, never the bypassed value.
    assign dbg_data = w_reg_q[dbg_num];

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_sb
//  Brief    : Scoreboard bench for regfile_sb, bypassing and non-bypassing
//             instances driven from the same stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    localparam int c_W  = 32;
    localparam int c_D  = 8;
    localparam int c_AW = 3;

    // Observed-signal selectors
    localparam int c_RDATA1    = 0;
    localparam int c_RDATA2    = 1;
    localparam int c_RBUSY1    = 2;
    localparam int c_RBUSY2    = 3;
    localparam int c_BUSYVEC   = 4;
    localparam int c_DBG       = 5;
    localparam int c_RDATA1_NB = 6;
    localparam int c_DBG_NB    = 7;
    localparam int c_RBUSY2_NB = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [c_AW-1:0] rnum1, rnum2, wnum, bnum, dbg_num;
    logic [c_W-1:0]  wdata;
    logic            write, bset;

    logic [c_W-1:0]  rdata1, rdata2, dbg_data;
    logic            rbusy1, rbusy2;
    logic [c_D-1:0]  busy_vec;

    logic [c_W-1:0]  nb_rdata1, nb_rdata2, nb_dbg_data;
    logic            nb_rbusy1, nb_rbusy2;
    logic [c_D-1:0]  nb_busy_vec;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       nm;
    } exp_t;

    exp_t q[$];

    regfile_sb #(.WIDTH(c_W), .DEPTH(c_D), .BYPASS(1)) dut (
        .clk(clk), .rst(rst),
        .rnum1(rnum1), .rnum2(rnum2),
        .rdata1(rdata1), .rdata2(rdata2),
        .rbusy1(rbusy1), .rbusy2(rbusy2),
        .write(write), .wnum(wnum), .wdata(wdata),
        .bset(bset), .bnum(bnum),
        .busy_vec(busy_vec),
        .dbg_num(dbg_num), .dbg_data(dbg_data)
    );

    regfile_sb #(.WIDTH(c_W), .DEPTH(c_D), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst),
        .rnum1(rnum1), .rnum2(rnum2),
        .rdata1(nb_rdata1), .rdata2(nb_rdata2),
        .rbusy1(nb_rbusy1), .rbusy2(nb_rbusy2),
        .write(write), .wnum(wnum), .wdata(wdata),
        .bset(bset), .bnum(bnum),
        .busy_vec(nb_busy_vec),
        .dbg_num(dbg_num), .dbg_data(nb_dbg_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            c_RDATA1:    return rdata1;
            c_RDATA2:    return rdata2;
            c_RBUSY1:    return {31'd0, rbusy1};
            c_RBUSY2:    return {31'd0, rbusy2};
            c_BUSYVEC:   return {24'd0, busy_vec};
            c_DBG:       return dbg_data;
            c_RDATA1_NB: return nb_rdata1;
            c_DBG_NB:    return nb_dbg_data;
            c_RBUSY2_NB: return {31'd0, nb_rbusy2};
            default:     return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: on each falling edge, retire every expectation due this cycle.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                logic [31:0] got;
                got = observe(q[i].sel);
                checks++;
                if (got !== q[i].val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", q[i].nm, cyc, got, q[i].val);
                end
                q.delete(i);
            end
        end
    end

    task automatic expect_val(input int sel, input logic [31:0] v, input int dly, input string nm);
        exp_t e;
        e.cyc = cyc + dly;
        e.sel = sel;
        e.val = v;
        e.nm  = nm;
        q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write = 1'b0;
        bset  = 1'b0;
    endtask

    initial begin
        rst = 1'b0; rnum1 = '0; rnum2 = '0; wnum = '0; bnum = '0; dbg_num = '0;
        wdata = '0; write = 1'b0; bset = 1'b0;

        // c1: reset held
        next_cycle();
        expect_val(c_RDATA1, 32'h0, 0, "rst_rdata1");
        expect_val(c_BUSYVEC, 32'h0, 0, "rst_busy");
        expect_val(c_DBG, 32'h0, 0, "rst_dbg");
        expect_val(c_RBUSY1, 32'h0, 0, "rst_rbusy1");

        // c2: write reg3 with simultaneous bset3, read it through bypass
        next_cycle();
        rst = 1'b1; write = 1'b1; wnum = 3'd3; wdata = 32'h1234;
        bset = 1'b1; bnum = 3'd3; dbg_num = 3'd3; rnum1 = 3'd3;
        expect_val(c_RDATA1, 32'h1234, 0, "pre_bypass");
        expect_val(c_RDATA1_NB, 32'h0, 0, "pre_nobypass");
        expect_val(c_RBUSY1, 32'h0, 0, "pre_rbusy1");
        expect_val(c_DBG, 32'h1234, 1, "pre_dbg3");
        expect_val(c_BUSYVEC, 32'h08, 1, "pre_busy3");
        expect_val(c_RBUSY1, 32'h1, 1, "pre_rbusy1_set");

        // c3
        next_cycle(); idle();

        // c4: asynchronous reset mid-cycle, with a write and bset pending
        next_cycle();
        rst = 1'b0; write = 1'b1; wnum = 3'd3; wdata = 32'h55;
        bset = 1'b1; bnum = 3'd5;
        expect_val(c_DBG, 32'h0, 0, "async_dbg3");
        expect_val(c_BUSYVEC, 32'h0, 0, "async_busy");
        expect_val(c_RDATA1, 32'h0, 0, "async_rdata1");
        expect_val(c_RBUSY1, 32'h0, 0, "async_rbusy1");

        // c5: release reset; the write/bset seen during reset must be gone
        next_cycle();
        rst = 1'b1; idle();
        expect_val(c_DBG, 32'h0, 0, "discard_dbg3");
        expect_val(c_BUSYVEC, 32'h0, 0, "discard_busy");

        // c6/c7: write then dual read of reg5
        next_cycle();
        write = 1'b1; wnum = 3'd5; wdata = 32'hDEAD_BEEF;
        next_cycle();
        idle(); rnum1 = 3'd5; rnum2 = 3'd5; dbg_num = 3'd5;
        expect_val(c_RDATA1, 32'hDEAD_BEEF, 0, "rd5_p1");
        expect_val(c_RDATA2, 32'hDEAD_BEEF, 0, "rd5_p2");
        expect_val(c_DBG, 32'hDEAD_BEEF, 0, "rd5_dbg");

        // c8: writes and bset to register 0 are ignored
        next_cycle();
        write = 1'b1; wnum = 3'd0; wdata = 32'hFFFF_FFFF; bset = 1'b1; bnum = 3'd0;
        rnum1 = 3'd0;
        expect_val(c_RDATA1, 32'h0, 0, "r0_bypass");
        expect_val(c_RBUSY1, 32'h0, 0, "r0_rbusy");
        expect_val(c_RDATA1, 32'h0, 1, "r0_after");
        expect_val(c_BUSYVEC, 32'h0, 1, "r0_busy");

        // c9
        next_cycle(); idle();

        // c10/c11: bypass vs committed state
        next_cycle();
        write = 1'b1; wnum = 3'd2; wdata = 32'h11;
        next_cycle();
        wdata = 32'h22; rnum1 = 3'd2; dbg_num = 3'd2;
        expect_val(c_RDATA1, 32'h22, 0, "byp_rdata1");
        expect_val(c_DBG, 32'h11, 0, "byp_dbg");
        expect_val(c_RDATA1_NB, 32'h11, 0, "nobyp_rdata1");
        expect_val(c_DBG_NB, 32'h11, 0, "nobyp_dbg");
        expect_val(c_DBG, 32'h22, 1, "byp_dbg_next");
        expect_val(c_RDATA1_NB, 32'h22, 1, "nobyp_rdata1_next");

        // c12
        next_cycle(); idle();

        // c13: mark reg4 busy
        next_cycle();
        bset = 1'b1; bnum = 3'd4; rnum2 = 3'd4;
        expect_val(c_RBUSY2, 32'h0, 0, "sb_rbusy2_pre");
        expect_val(c_BUSYVEC, 32'h10, 1, "sb_busy4");
        expect_val(c_RBUSY2, 32'h1, 1, "sb_rbusy2");
        expect_val(c_RBUSY2_NB, 32'h1, 1, "sb_rbusy2_nb");

        // c14
        next_cycle(); idle();

        // c15: producer completes on reg4
        next_cycle();
        write = 1'b1; wnum = 3'd4; wdata = 32'h7;
        expect_val(c_RBUSY2, 32'h0, 0, "sb_wr_rbusy2");
        expect_val(c_RBUSY2_NB, 32'h1, 0, "sb_wr_rbusy2_nb");
        expect_val(c_RDATA2, 32'h7, 0, "sb_wr_rdata2");
        expect_val(c_BUSYVEC, 32'h10, 0, "sb_wr_busy_still");
        expect_val(c_BUSYVEC, 32'h0, 1, "sb_clear");
        expect_val(c_RBUSY2, 32'h0, 1, "sb_clear_rbusy2");
        expect_val(c_RDATA2, 32'h7, 1, "sb_rdata2");

        // c16
        next_cycle(); idle();

        // c17..c19: bset/write collision on busy reg6
        next_cycle();
        bset = 1'b1; bnum = 3'd6; rnum1 = 3'd6;
        expect_val(c_BUSYVEC, 32'h40, 1, "col_busy6_pre");
        expect_val(c_RBUSY1, 32'h1, 1, "col_rbusy1_pre");
        next_cycle(); idle();
        next_cycle();
        bset = 1'b1; bnum = 3'd6; write = 1'b1; wnum = 3'd6; wdata = 32'h99; dbg_num = 3'd6;
        expect_val(c_RBUSY1, 32'h1, 0, "col_rbusy1");
        expect_val(c_RDATA1, 32'h99, 0, "col_rdata1");
        expect_val(c_DBG, 32'h0, 0, "col_dbg_pre");
        expect_val(c_DBG, 32'h99, 1, "col_dbg");
        expect_val(c_BUSYVEC, 32'h40, 1, "col_busy6");
        expect_val(c_RBUSY1, 32'h1, 1, "col_rbusy1_next");
        expect_val(c_RDATA1_NB, 32'h99, 1, "col_rdata1_nb");

        // c20
        next_cycle(); idle();

        // c21: top register, distinct read addresses
        next_cycle();
        write = 1'b1; wnum = 3'd7; wdata = 32'hA5A5_A5A5;
        rnum1 = 3'd5; rnum2 = 3'd2; dbg_num = 3'd7;
        expect_val(c_RDATA1, 32'hDEAD_BEEF, 0, "mix_rdata1");
        expect_val(c_RDATA2, 32'h22, 0, "mix_rdata2");
        expect_val(c_DBG, 32'hA5A5_A5A5, 1, "top_dbg7");

        next_cycle(); idle();
        next_cycle();
        next_cycle();

        if (q.size() != 0) begin
            errors += q.size();
            $display("FAIL pending_expectations got=%0d exp=0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
